// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - two-master round-robin arbiter for the single-port on-chip RAM
// Optional performance counters: define ONCHIP_ARB_PERF_CNT_EN
module onchip_mem_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
`ifdef ONCHIP_ARB_PERF_CNT_EN
  ,
  input  logic                  perf_clear,
  output logic [31:0]           perf_grant0,
  output logic [31:0]           perf_grant1,
  output logic [31:0]           perf_stall0,
  output logic [31:0]           perf_stall1
`endif
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t     state;
  logic       rr_ptr;
  logic [3:0] burst_cnt;
  logic       rd_pending;
  logic       rd_tag;

  logic req0, req1;
  logic grant0, grant1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grant decision: combinational from live requests and the registered ownership state
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
            grant0 = ~rr_ptr;
            grant1 = rr_ptr;
          end else begin
            grant0 = req0;
            grant1 = req1;
          end
        end
        OWN0: begin
          if (req0 && (!req1 || burst_cnt < MAX_B)) grant0 = 1'b1;
          else                                      grant1 = req1;
        end
        OWN1: begin
          if (req1 && (!req0 || burst_cnt < MAX_B)) grant1 = 1'b1;
          else                                      grant0 = req0;
        end
        default: begin
          grant0 = 1'b0;
          grant1 = 1'b0;
        end
      endcase
    end
  end

  assign m0_waitrequest = ~grant0;
  assign m1_waitrequest = ~grant1;
  assign mem_chipselect = grant0 | grant1;
  assign mem_clken      = ~reset;

  // RAM port mux: only the granted master reaches the RAM, otherwise drive quiet zeros
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    if (grant0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_write      = m0_write;
      mem_writedata  = m0_writedata;
    end else if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_write      = m1_write;
      mem_writedata  = m1_writedata;
    end
  end

  // Ownership FSM: burst counting, handover and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      burst_cnt <= '0;
    end else if (grant0) begin
      if (state == OWN0) begin
        if (burst_cnt != 4'hF) burst_cnt <= burst_cnt + 4'd1;
      end else begin
        state     <= OWN0;
        burst_cnt <= 4'd1;
        rr_ptr    <= 1'b1;
      end
    end else if (grant1) begin
      if (state == OWN1) begin
        if (burst_cnt != 4'hF) burst_cnt <= burst_cnt + 4'd1;
      end else begin
        state     <= OWN1;
        burst_cnt <= 4'd1;
        rr_ptr    <= 1'b0;
      end
    end else if (state != IDLE) begin
      rr_ptr    <= (state == OWN0);
      state     <= IDLE;
      burst_cnt <= '0;
    end
  end

  // Read return pipeline: one stage matching the RAM latency, tagged with the requester
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending <= 1'b0;
      rd_tag     <= 1'b0;
    end else begin
      rd_pending <= (grant0 && m0_read && !m0_write) || (grant1 && m1_read && !m1_write);
      rd_tag     <= grant1;
    end
  end

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pending && !rd_tag && !reset;
  assign m1_readdatavalid = rd_pending &&  rd_tag && !reset;

`ifdef ONCHIP_ARB_PERF_CNT_EN
  // Saturating grant/stall counters; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (reset || perf_clear) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall0 <= '0;
      perf_stall1 <= '0;
    end else begin
      if (grant0 && perf_grant0 != 32'hFFFF_FFFF)          perf_grant0 <= perf_grant0 + 32'd1;
      if (grant1 && perf_grant1 != 32'hFFFF_FFFF)          perf_grant1 <= perf_grant1 + 32'd1;
      if (req0 && !grant0 && perf_stall0 != 32'hFFFF_FFFF) perf_stall0 <= perf_stall0 + 32'd1;
      if (req1 && !grant1 && perf_stall1 != 32'hFFFF_FFFF) perf_stall1 <= perf_stall1 + 32'd1;
    end
  end
`endif

endmodule
